// File: rtl/snax_acc_shell_pkg.sv
// ----------------------------------------------------------------------------
// snax_acc_shell_pkg
// Shared types and constants for the SNAX accelerator shell control block:
//   - run-state enumeration of the control FSM
//   - indices of the read-only CSR words
//   - bit positions inside the status word
// ----------------------------------------------------------------------------
package snax_acc_shell_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CFG  = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // Read-only CSR word map: status, perf counter, then output-stream beat
    // counters, then input-stream beat counters.
    localparam int StatusIdx  = 0;
    localparam int PerfIdx    = 1;
    localparam int OutCntBase = 2;

    // Status word bit positions.
    localparam int StatusBusyBit = 0;
    localparam int StatusSatBit  = 1;

endpackage

// File: rtl/snax_sat_counter.sv
// ----------------------------------------------------------------------------
// snax_sat_counter
// Saturating up-counter with synchronous clear. Clear has priority over
// increment; once all ones the count holds instead of wrapping.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset (count -> 0)
//   clr_i   synchronous clear
//   inc_i   increment request
//   cnt_o   current count
//   sat_o   count is at its maximum value
// ----------------------------------------------------------------------------
module snax_sat_counter #(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o,
    output logic             sat_o
);

    logic [Width-1:0] r_cnt;
    logic             w_sat;

    assign w_sat = &r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (inc_i && !w_sat) begin
            r_cnt <= r_cnt + Width'(1);
        end
    end

    assign cnt_o = r_cnt;
    assign sat_o = w_sat;

endmodule

// File: rtl/snax_acc_shell_ctrl.sv
// ----------------------------------------------------------------------------
// snax_acc_shell_ctrl
// Control front-end between the SNAX CSR manager and an accelerator core.
// Registers the config handoff, tracks IDLE/CFG/RUN, counts busy cycles and
// per-stream handshake beats, and exports them as read-only CSR words.
// Stream datapaths bypass this block; only valid/ready pairs are observed.
//
// Ports (word k of a flat CSR bus sits at bits [k*RegDataWidth +: RegDataWidth]):
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   csr_reg_set_i          RW config words (word 0 = mode)
//   csr_reg_set_valid_i    config write request
//   csr_reg_set_ready_o    config write accepted (high only in IDLE)
//   csr_reg_ro_set_o       RO status words (status, perf, out counts, in counts)
//   core_cfg_o             registered config presented to the core
//   core_cfg_valid_o       config valid to the core (high in CFG)
//   core_cfg_ready_i       core accepts config
//   core_busy_i            core busy flag
//   in_valid_i/in_ready_i  observed stream2acc handshakes
//   out_valid_i/out_ready_i observed acc2stream handshakes
// ----------------------------------------------------------------------------
module snax_acc_shell_ctrl
    import snax_acc_shell_pkg::*;
#(
    parameter int  NumInStreams  = 14,
    parameter int  NumOutStreams = 4,
    parameter int  RegRWCount    = 7,
    parameter int  RegDataWidth  = 32,
    parameter int  CntWidth      = 32,
    localparam int RegROCount    = 2 + NumOutStreams + NumInStreams
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [RegRWCount*RegDataWidth-1:0] csr_reg_set_i,
    input  logic                               csr_reg_set_valid_i,
    output logic                               csr_reg_set_ready_o,
    output logic [RegROCount*RegDataWidth-1:0] csr_reg_ro_set_o,
    output logic [RegRWCount*RegDataWidth-1:0] core_cfg_o,
    output logic                               core_cfg_valid_o,
    input  logic                               core_cfg_ready_i,
    input  logic                               core_busy_i,
    input  logic [NumInStreams-1:0]            in_valid_i,
    input  logic [NumInStreams-1:0]            in_ready_i,
    input  logic [NumOutStreams-1:0]           out_valid_i,
    input  logic [NumOutStreams-1:0]           out_ready_i
);

    // Counter slots: 0 = perf, 1..NumOutStreams = out streams, then in streams.
    localparam int NumCnt    = 1 + NumOutStreams + NumInStreams;
    localparam int InCntBase = OutCntBase + NumOutStreams;

    state_e                             r_state;
    state_e                             w_state_nxt;
    logic                               r_first_run;
    logic [RegRWCount*RegDataWidth-1:0] r_cfg;
    logic                               w_accept;
    logic [NumCnt-1:0]                  w_cnt_inc;
    logic [NumCnt-1:0]                  w_cnt_sat;
    logic [CntWidth-1:0]                w_cnt [NumCnt];
    logic [RegROCount*RegDataWidth-1:0] w_ro;

    // A CSR write is only taken in IDLE; otherwise it stalls on ready=0.
    assign w_accept = (r_state == ST_IDLE) && csr_reg_set_valid_i;

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_first_run <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            // Set only for the first RUN cycle so the core gets one cycle to
            // raise busy before its absence is taken as completion.
            r_first_run <= (r_state == ST_CFG) && core_cfg_ready_i;
        end
    end

    // ---------------- FSM next-state and outputs ----------------
    always_comb begin
        w_state_nxt         = r_state;
        csr_reg_set_ready_o = 1'b0;
        core_cfg_valid_o    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                csr_reg_set_ready_o = 1'b1;
                if (csr_reg_set_valid_i) w_state_nxt = ST_CFG;
            end
            ST_CFG: begin
                core_cfg_valid_o = 1'b1;
                if (core_cfg_ready_i) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!r_first_run && !core_busy_i) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- config register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cfg <= '0;
        end else if (w_accept) begin
            r_cfg <= csr_reg_set_i;
        end
    end

    assign core_cfg_o = r_cfg;

    // ---------------- counters ----------------
    always_comb begin
        w_cnt_inc    = '0;
        // The exit cycle of RUN is not counted as busy.
        w_cnt_inc[0] = (r_state == ST_RUN) && (r_first_run || core_busy_i);
        for (int j = 0; j < NumOutStreams; j++) begin
            w_cnt_inc[1 + j] = out_valid_i[j] & out_ready_i[j];
        end
        for (int i = 0; i < NumInStreams; i++) begin
            w_cnt_inc[1 + NumOutStreams + i] = in_valid_i[i] & in_ready_i[i];
        end
    end

    for (genvar k = 0; k < NumCnt; k++) begin : g_cnt
        snax_sat_counter #(
            .Width (CntWidth)
        ) u_cnt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (w_accept),
            .inc_i  (w_cnt_inc[k]),
            .cnt_o  (w_cnt[k]),
            .sat_o  (w_cnt_sat[k])
        );
    end

    // ---------------- RO word assembly (from registered state only) ----------------
    always_comb begin
        w_ro = '0;
        w_ro[StatusIdx*RegDataWidth + StatusBusyBit] = (r_state != ST_IDLE);
        w_ro[StatusIdx*RegDataWidth + StatusSatBit]  = |w_cnt_sat;
        w_ro[PerfIdx*RegDataWidth +: CntWidth]       = w_cnt[0];
        for (int j = 0; j < NumOutStreams; j++) begin
            w_ro[(OutCntBase + j)*RegDataWidth +: CntWidth] = w_cnt[1 + j];
        end
        for (int i = 0; i < NumInStreams; i++) begin
            w_ro[(InCntBase + i)*RegDataWidth +: CntWidth] = w_cnt[1 + NumOutStreams + i];
        end
    end

    assign csr_reg_ro_set_o = w_ro;

endmodule

// File: tb/tb_snax_acc_shell_ctrl.sv
// ----------------------------------------------------------------------------
// tb_snax_acc_shell_ctrl
// Directed bench for snax_acc_shell_ctrl. A default instance (32-bit counters)
// and a CntWidth=4 instance share all inputs; the narrow one is used for the
// saturation scenario.
// ----------------------------------------------------------------------------
module tb_snax_acc_shell_ctrl;

    localparam int NIN  = 14;
    localparam int NOUT = 4;
    localparam int RW   = 7;
    localparam int DW   = 32;
    localparam int ROC  = 2 + NOUT + NIN;

    logic                clk;
    logic                rst_n;
    logic [RW*DW-1:0]    csr_set;
    logic                csr_valid;
    logic                core_ready;
    logic                core_busy;
    logic [NIN-1:0]      in_valid;
    logic [NIN-1:0]      in_ready;
    logic [NOUT-1:0]     out_valid;
    logic [NOUT-1:0]     out_ready;

    logic                ready_a,  ready_b;
    logic [ROC*DW-1:0]   ro_a,     ro_b;
    logic [RW*DW-1:0]    cfg_a,    cfg_b;
    logic                cfgv_a,   cfgv_b;

    int vectors;
    int miscompares;

    snax_acc_shell_ctrl u_dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .csr_reg_set_i       (csr_set),
        .csr_reg_set_valid_i (csr_valid),
        .csr_reg_set_ready_o (ready_a),
        .csr_reg_ro_set_o    (ro_a),
        .core_cfg_o          (cfg_a),
        .core_cfg_valid_o    (cfgv_a),
        .core_cfg_ready_i    (core_ready),
        .core_busy_i         (core_busy),
        .in_valid_i          (in_valid),
        .in_ready_i          (in_ready),
        .out_valid_i         (out_valid),
        .out_ready_i         (out_ready)
    );

    snax_acc_shell_ctrl #(.CntWidth(4)) u_dut4 (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .csr_reg_set_i       (csr_set),
        .csr_reg_set_valid_i (csr_valid),
        .csr_reg_set_ready_o (ready_b),
        .csr_reg_ro_set_o    (ro_b),
        .core_cfg_o          (cfg_b),
        .core_cfg_valid_o    (cfgv_b),
        .core_cfg_ready_i    (core_ready),
        .core_busy_i         (core_busy),
        .in_valid_i          (in_valid),
        .in_ready_i          (in_ready),
        .out_valid_i         (out_valid),
        .out_ready_i         (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [RW*DW-1:0] pack7(input logic [31:0] a, b, c, d, e, f, g);
        return {g, f, e, d, c, b, a};
    endfunction

    function automatic logic [31:0] ro_w(input logic [ROC*DW-1:0] v, input int idx);
        return v[idx*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        csr_valid  = 1'b0;
        core_ready = 1'b0;
        core_busy  = 1'b0;
        in_valid   = '0;
        in_ready   = '0;
        out_valid  = '0;
        out_ready  = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        csr_set = '0;
        rst_n   = 1'b0;
        #1;
        vectors++; if (ready_a !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %0b want 1", ready_a); end
        vectors++; if (cfgv_a !== 1'b0) begin miscompares++; $display("FAIL rst_cfg_valid: got %0b want 0", cfgv_a); end
        vectors++; if (cfg_a !== '0) begin miscompares++; $display("FAIL rst_cfg: got %0h want 0", cfg_a); end
        vectors++; if (ro_a !== '0) begin miscompares++; $display("FAIL rst_ro: got %0h want 0", ro_a); end
        vectors++; if ({ready_b, cfgv_b} !== 2'b10 || cfg_b !== '0 || ro_b !== '0) begin
            miscompares++; $display("FAIL rst_dut4: ready %0b valid %0b cfg %0h ro %0h want 1 0 0 0", ready_b, cfgv_b, cfg_b, ro_b);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        vectors++; if (ready_a !== 1'b1 || ro_a !== '0) begin
            miscompares++; $display("FAIL rst_release: ready %0b ro %0h want 1 0", ready_a, ro_a);
        end
    endtask

    task automatic test_basic_run();
        logic [RW*DW-1:0] w;
        w = pack7(1, 16, 64, 4, 128, 32, 0);
        csr_set = w; csr_valid = 1'b1; core_ready = 1'b1; core_busy = 1'b1;
        tick();  // CFG
        csr_valid = 1'b0;
        vectors++; if (cfgv_a !== 1'b1) begin miscompares++; $display("FAIL basic_cfgv_rise: got %0b want 1", cfgv_a); end
        vectors++; if (cfg_a !== w) begin miscompares++; $display("FAIL basic_cfg: got %0h want %0h", cfg_a, w); end
        vectors++; if (ready_a !== 1'b0) begin miscompares++; $display("FAIL basic_ready_cfg: got %0b want 0", ready_a); end
        tick();  // RUN1
        vectors++; if (cfgv_a !== 1'b0) begin miscompares++; $display("FAIL basic_cfgv_drop: got %0b want 0", cfgv_a); end
        vectors++; if (ro_w(ro_a, 0) !== 32'h1) begin miscompares++; $display("FAIL basic_status_run: got %0h want 1", ro_w(ro_a, 0)); end
        repeat (10) tick();  // busy counted RUN1..RUN10, now in RUN11
        core_busy = 1'b0;
        vectors++; if (ro_w(ro_a, 1) !== 32'd10) begin miscompares++; $display("FAIL basic_perf_run: got %0d want 10", ro_w(ro_a, 1)); end
        tick();  // IDLE
        vectors++; if (ro_w(ro_a, 1) !== 32'd10) begin miscompares++; $display("FAIL basic_perf_exit: got %0d want 10", ro_w(ro_a, 1)); end
        vectors++; if (ro_w(ro_a, 0) !== 32'h0) begin miscompares++; $display("FAIL basic_status_idle: got %0h want 0", ro_w(ro_a, 0)); end
        vectors++; if (ready_a !== 1'b1) begin miscompares++; $display("FAIL basic_ready_idle: got %0b want 1", ready_a); end
    endtask

    task automatic test_beats();
        int nz;
        csr_set = pack7(2, 1, 2, 3, 4, 5, 6); csr_valid = 1'b1; core_ready = 1'b1; core_busy = 1'b1;
        tick();  // CFG
        csr_valid = 1'b0;
        tick();  // RUN1
        for (int i = 0; i < 8; i++) begin
            out_valid    = '0; out_ready = '0; in_valid = '0; in_ready = '0;
            out_valid[2] = (i < 5); out_ready[2] = 1'b1;
            out_valid[1] = 1'b1;    out_ready[1] = 1'b0;
            in_valid[0]  = 1'b1;    in_ready[0]  = (i < 7);
            in_valid[3]  = 1'b1;    in_ready[5]  = 1'b1;
            tick();
        end
        out_valid = '0; out_ready = '0; in_valid = '0; in_ready = '0;
        vectors++; if (ro_w(ro_a, 4) !== 32'd5) begin miscompares++; $display("FAIL beats_out2: got %0d want 5", ro_w(ro_a, 4)); end
        vectors++; if (ro_w(ro_a, 6) !== 32'd7) begin miscompares++; $display("FAIL beats_in0: got %0d want 7", ro_w(ro_a, 6)); end
        nz = 0;
        for (int k = 2; k < ROC; k++) begin
            if (k != 4 && k != 6 && ro_w(ro_a, k) != 0) nz++;
        end
        vectors++; if (nz !== 0) begin miscompares++; $display("FAIL beats_others: got %0d nonzero words want 0", nz); end
        core_busy = 1'b0;
        tick();  // IDLE
    endtask

    task automatic test_backpressure();
        logic [RW*DW-1:0] w;
        w = pack7(3, 'hA, 'hB, 'hC, 'hD, 'hE, 'hF);
        csr_set = w; csr_valid = 1'b1; core_ready = 1'b0; core_busy = 1'b0;
        tick();  // CFG
        csr_valid = 1'b0;
        csr_set   = pack7('hDEAD, 'hDEAD, 'hDEAD, 'hDEAD, 'hDEAD, 'hDEAD, 'hDEAD);
        for (int c = 0; c < 5; c++) begin
            vectors++; if (cfgv_a !== 1'b1 || cfg_a !== w || ro_w(ro_a, 1) !== 32'd0) begin
                miscompares++; $display("FAIL bp_hold%0d: valid %0b cfg %0h perf %0d want 1 %0h 0", c, cfgv_a, cfg_a, ro_w(ro_a, 1), w);
            end
            if (c < 4) tick();
        end
        core_ready = 1'b1;
        tick();  // RUN1, busy low is ignored here
        vectors++; if (cfgv_a !== 1'b0 || ro_w(ro_a, 1) !== 32'd0) begin
            miscompares++; $display("FAIL bp_run_entry: valid %0b perf %0d want 0 0", cfgv_a, ro_w(ro_a, 1));
        end
        tick();  // RUN2 via guard
        vectors++; if (ro_w(ro_a, 0) !== 32'h1 || ro_w(ro_a, 1) !== 32'd1) begin
            miscompares++; $display("FAIL bp_guard: status %0h perf %0d want 1 1", ro_w(ro_a, 0), ro_w(ro_a, 1));
        end
        tick();  // IDLE
        vectors++; if (ro_w(ro_a, 0) !== 32'h0 || ro_w(ro_a, 1) !== 32'd1) begin
            miscompares++; $display("FAIL bp_exit: status %0h perf %0d want 0 1", ro_w(ro_a, 0), ro_w(ro_a, 1));
        end
    endtask

    task automatic test_stalled_write();
        logic [RW*DW-1:0] wa, wb;
        wa = pack7(4, 11, 12, 13, 14, 15, 16);
        wb = pack7(5, 21, 22, 23, 24, 25, 26);
        csr_set = wa; csr_valid = 1'b1; core_ready = 1'b1; core_busy = 1'b1;
        tick();  // CFG
        csr_valid = 1'b0;
        tick();  // RUN1
        out_valid[0] = 1'b1; out_ready[0] = 1'b1;
        repeat (3) tick();  // RUN4, out0 = 3
        out_valid = '0; out_ready = '0;
        csr_set = wb; csr_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            vectors++; if (ready_a !== 1'b0 || cfg_a !== wa) begin
                miscompares++; $display("FAIL stall_run%0d: ready %0b cfg %0h want 0 %0h", c, ready_a, cfg_a, wa);
            end
            tick();
        end
        core_busy = 1'b0;  // RUN6 exits
        tick();  // IDLE, pending write is accepted this cycle
        vectors++; if (ready_a !== 1'b1 || ro_w(ro_a, 2) !== 32'd3 || ro_w(ro_a, 1) !== 32'd5) begin
            miscompares++; $display("FAIL stall_idle: ready %0b out0 %0d perf %0d want 1 3 5", ready_a, ro_w(ro_a, 2), ro_w(ro_a, 1));
        end
        out_valid[0] = 1'b1; out_ready[0] = 1'b1;
        tick();  // CFG
        out_valid = '0; out_ready = '0; csr_valid = 1'b0;
        vectors++; if (cfg_a !== wb || cfgv_a !== 1'b1) begin
            miscompares++; $display("FAIL stall_accept: cfg %0h valid %0b want %0h 1", cfg_a, cfgv_a, wb);
        end
        vectors++; if (ro_w(ro_a, 2) !== 32'd0 || ro_w(ro_a, 1) !== 32'd0) begin
            miscompares++; $display("FAIL stall_clear: out0 %0d perf %0d want 0 0", ro_w(ro_a, 2), ro_w(ro_a, 1));
        end
        tick();  // RUN1
        tick();  // RUN2, exits
        tick();  // IDLE
    endtask

    task automatic test_saturation();
        csr_set = pack7(6, 0, 0, 0, 0, 0, 0); csr_valid = 1'b1; core_ready = 1'b0; core_busy = 1'b0;
        tick();  // CFG, hold here
        csr_valid = 1'b0;
        out_valid[0] = 1'b1; out_ready[0] = 1'b1;
        repeat (14) tick();
        vectors++; if (ro_w(ro_b, 2) !== 32'd14 || ro_w(ro_b, 0) !== 32'h1) begin
            miscompares++; $display("FAIL sat_14: cnt %0d status %0h want 14 1", ro_w(ro_b, 2), ro_w(ro_b, 0));
        end
        tick();
        vectors++; if (ro_w(ro_b, 2) !== 32'd15 || ro_w(ro_b, 0) !== 32'h3) begin
            miscompares++; $display("FAIL sat_15: cnt %0d status %0h want 15 3", ro_w(ro_b, 2), ro_w(ro_b, 0));
        end
        repeat (5) tick();
        vectors++; if (ro_w(ro_b, 2) !== 32'd15 || ro_w(ro_b, 0) !== 32'h3) begin
            miscompares++; $display("FAIL sat_hold: cnt %0d status %0h want 15 3", ro_w(ro_b, 2), ro_w(ro_b, 0));
        end
        vectors++; if (ro_w(ro_a, 2) !== 32'd20 || ro_w(ro_a, 0) !== 32'h1) begin
            miscompares++; $display("FAIL sat_wide: cnt %0d status %0h want 20 1", ro_w(ro_a, 2), ro_w(ro_a, 0));
        end
        out_valid = '0; out_ready = '0; core_ready = 1'b1;
        tick();  // RUN1
        tick();  // RUN2, exits
        tick();  // IDLE
    endtask

    task automatic test_reset_midrun();
        csr_set = pack7(7, 1, 1, 1, 1, 1, 1); csr_valid = 1'b1; core_ready = 1'b1; core_busy = 1'b1;
        tick();  // CFG
        csr_valid = 1'b0;
        tick();  // RUN1
        repeat (37) tick();
        vectors++; if (ro_w(ro_a, 1) !== 32'd37) begin miscompares++; $display("FAIL midrun_perf: got %0d want 37", ro_w(ro_a, 1)); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (ready_a !== 1'b1 || cfgv_a !== 1'b0 || cfg_a !== '0 || ro_a !== '0) begin
            miscompares++; $display("FAIL midrun_async: ready %0b valid %0b cfg %0h ro %0h want 1 0 0 0", ready_a, cfgv_a, cfg_a, ro_a);
        end
        vectors++; if (ro_b !== '0) begin miscompares++; $display("FAIL midrun_async4: ro %0h want 0", ro_b); end
        idle_inputs();
        rst_n = 1'b1;
        tick();
        vectors++; if (ready_a !== 1'b1 || ro_w(ro_a, 0) !== 32'h0) begin
            miscompares++; $display("FAIL midrun_release: ready %0b status %0h want 1 0", ready_a, ro_w(ro_a, 0));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic_run();
        test_beats();
        test_backpressure();
        test_stalled_write();
        test_saturation();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
